// File: rtl/alu_pkg.sv
// Shared ALU definitions: result width and the packed buffer entry type.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              compare;
    logic              zero;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer between the ALU and its consumer, with a carry flag
// register fed back to the ALU carry_in for multi-word chaining.
module alu_result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_compare,
  input  logic              in_flag_we,
  input  logic              flag_clear,
  output logic              carry_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_compare,
  output logic              out_zero,
  output logic [1:0]        count
);
  import alu_pkg::*;

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  alu_entry_t head_q, tail_q, head_d, tail_d, new_entry;
  logic [1:0] count_q, count_d;
  logic       ready_q, ready_d;
  logic       carry_flag_q;
  logic       push, pop;

  assign push = in_valid && ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    new_entry.result  = in_result;
    new_entry.carry   = in_carry;
    new_entry.compare = in_compare;
    new_entry.zero    = (in_result == '0);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    // Push and pop together only happens at count 1 (full blocks push,
    // empty blocks pop), so the new entry goes straight to the head.
    if (pop) begin
      head_d = push ? new_entry : tail_q;
    end else if (push) begin
      if (count_q == 2'd0) head_d = new_entry;
      else                 tail_d = new_entry;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Registered ready keeps in_ready low during reset and free of any
    // combinational path from out_ready.
    ready_d = (count_d != FULL_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 carry_flag_q <= 1'b0;
    else if (flag_clear)        carry_flag_q <= 1'b0;
    else if (push && in_flag_we) carry_flag_q <= in_carry;
  end

  assign in_ready    = ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign count       = count_q;
  assign carry_flag  = carry_flag_q;
  assign out_result  = head_q.result;
  assign out_carry   = head_q.carry;
  assign out_compare = head_q.compare;
  assign out_zero    = head_q.zero;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the result width, matching the 16-bit ALU output.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that an ALU result is presented.
REQ-006 in_ready  output  1  SHALL indicate that the buffer can accept a result this cycle.
REQ-007 in_result  input  DATA_W  SHALL be the ALU result word (alu_out).
REQ-008 in_carry  input  1  SHALL be the ALU carry_out.
REQ-009 in_compare  input  1  SHALL be the ALU compare (A==B) output.
REQ-010 in_flag_we  input  1  SHALL request that the carry flag be updated when the current result is accepted.
REQ-011 flag_clear  input  1  SHALL synchronously clear the carry flag.
REQ-012 carry_flag  output  1  SHALL be the registered carry fed back to the ALU carry_in for multi-word chaining.
REQ-013 out_valid  output  1  SHALL indicate that the head entry is valid.
REQ-014 out_ready  input  1  SHALL indicate that the consumer takes the head entry this cycle.
REQ-015 out_result  output  DATA_W  SHALL be the head entry result.
REQ-016 out_carry  output  1  SHALL be the head entry carry.
REQ-017 out_compare  output  1  SHALL be the head entry compare bit.
REQ-018 out_zero  output  1  SHALL be 1 when the head entry result equals 0.
REQ-019 count  output  2  SHALL report the current occupancy, 0..2.

Function
REQ-020 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL equal (count != 2), derived from registered state only, with no combinational path from out_ready.
REQ-022 out_valid SHALL equal (count != 0), and the out_* fields SHALL come from registers only.
REQ-023 Latency: a result pushed into an empty buffer in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1.
REQ-024 The zero bit SHALL be computed at push time as (in_result == 0) and stored with the entry.
REQ-025 Entries SHALL leave in push order; a push and a pop in the same cycle at count=1 SHALL keep count at 1, and the new entry SHALL become the head in the next cycle.
REQ-026 When count=2, no push SHALL occur; a pop SHALL move entry 1 to head and set count to 1.
REQ-027 A pop at count=0 SHALL be impossible (out_valid=0), and count SHALL never wrap.
REQ-028 While out_valid=1 and out_ready=0, the out_* fields SHALL hold stable.
REQ-029 On a push with in_flag_we=1, carry_flag SHALL load in_carry in the next cycle; otherwise it SHALL hold.
REQ-030 If flag_clear=1, carry_flag SHALL become 0 in the next cycle, taking priority over REQ-029 in the same cycle.
REQ-031 in_flag_we SHALL be ignored when no push occurs.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force count=0, out_valid=0, in_ready=0, carry_flag=0, out_result=0, out_carry=0, out_compare=0 and out_zero=0.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 from the first rising edge onward.
REQ-034 A reset mid-operation SHALL discard all buffered entries; no entry SHALL be delivered after reset.

Structure
REQ-035 DATA_W and a packed entry type {result, carry, compare, zero} SHALL reside in shared package alu_pkg.
REQ-036 Storage SHALL be two entry registers plus a count register, implemented inline; no sub-module is required.

Verification
REQ-037 Reset, then push in_result=16'h0000 with in_carry=0 and in_compare=1 -> next cycle out_valid=1, out_zero=1, out_compare=1, count=1.
REQ-038 Hold out_ready=0 and push 16'h1234 then 16'hABCD -> count=2, in_ready=0, and a third in_valid is not accepted; release out_ready -> 16'h1234 then 16'hABCD are delivered in order.
REQ-039 At count=1, push 16'h0005 while popping -> count stays 1, and the head is 16'h0005 in the following cycle.
REQ-040 Push with in_carry=1 and in_flag_we=1 -> carry_flag=1; push with in_flag_we=0 and in_carry=0 -> carry_flag stays 1; assert flag_clear together with a flag write of 1 -> carry_flag=0.
REQ-041 With count=2, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and count=0 before the next edge, and no stale data after release.
REQ-042 Random valid/ready traffic over 10k cycles -> the output sequence matches a scoreboard, with no loss, duplication or reordering.
